// File: rtl/sobel_window_gen.sv
// 3x3 neighbourhood generator for a raster-order 8-bit pixel stream using two line buffers.
// Optional frame-start marker output po_sof is built only when SOBEL_WIN_SOF_EN is defined.
module sobel_window_gen #(
  parameter int IMG_W = 100,
  parameter int IMG_H = 100
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        pi_flag,
  input  logic [7:0]  pi_data,
`ifdef SOBEL_WIN_SOF_EN
  output logic        po_sof,
`endif
  output logic        po_flag,
  output logic [71:0] po_win
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0] col, col_q;
  logic [RW-1:0] row, row_q;
  logic          v1;
  logic [7:0]    pix_q, lb1_q, lb2_q;
  logic [7:0]    lb1 [IMG_W];
  logic [7:0]    lb2 [IMG_W];
  logic [7:0]    top_x1, top_x0, mid_x1, mid_x0, bot_x1, bot_x0;
  logic          win_hit;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      col <= '0;
      row <= '0;
    end else if (pi_flag) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Line buffers carry no reset so they map onto RAM; nonblocking reads return pre-write data.
  always_ff @(posedge sys_clk) begin
    if (pi_flag) begin
      lb1_q    <= lb1[col];
      lb2_q    <= lb2[col];
      lb2[col] <= lb1[col];
      lb1[col] <= pi_data;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      v1    <= 1'b0;
      col_q <= '0;
      row_q <= '0;
      pix_q <= '0;
    end else begin
      v1 <= pi_flag;
      if (pi_flag) begin
        col_q <= col;
        row_q <= row;
        pix_q <= pi_data;
      end
    end
  end

  assign win_hit = v1 && (row_q >= ROW_TWO) && (col_q >= COL_TWO);

  // x1/x0 hold columns c-2/c-1; the stage-1 registers supply column c.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      top_x1  <= '0;
      top_x0  <= '0;
      mid_x1  <= '0;
      mid_x0  <= '0;
      bot_x1  <= '0;
      bot_x0  <= '0;
      po_flag <= 1'b0;
      po_win  <= '0;
    end else begin
      po_flag <= win_hit;
      if (v1) begin
        top_x1 <= top_x0;
        top_x0 <= lb2_q;
        mid_x1 <= mid_x0;
        mid_x0 <= lb1_q;
        bot_x1 <= bot_x0;
        bot_x0 <= pix_q;
      end
      if (win_hit) begin
        po_win <= {top_x1, top_x0, lb2_q,
                   mid_x1, mid_x0, lb1_q,
                   bot_x1, bot_x0, pix_q};
      end
    end
  end

`ifdef SOBEL_WIN_SOF_EN
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) po_sof <= 1'b0;
    else            po_sof <= win_hit && (row_q == ROW_TWO) && (col_q == COL_TWO);
  end
`endif

endmodule

// File: tb/tb_sobel_window_gen.sv
// Bench for sobel_window_gen: a 4x4 and a 5x3 instance checked against an image-array model.
// Frame-start marker checks are compiled in when SOBEL_WIN_SOF_EN is defined.
module tb_sobel_window_gen;

  typedef struct {
    logic [71:0] win;
    int          due;
    bit          sof;
  } exp_t;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [1:0]  pi_flag_s = '0;
  logic [7:0]  pi_data_s [2];
  logic [1:0]  po_flag_s;
  logic [71:0] po_win_s [2];
`ifdef SOBEL_WIN_SOF_EN
  logic [1:0]  po_sof_s;
`endif

  int          edge_cnt = 0;
  int          n_assert = 0;
  int          n_fail = 0;
  int          pulse_cnt [2];
  logic [71:0] win_log [2][16];
  exp_t        q [2][$];
  logic [7:0]  img [2][4][5];
  int          row_m [2];
  int          col_m [2];
  int          w_s [2] = '{4, 5};
  int          h_s [2] = '{4, 3};

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) edge_cnt <= edge_cnt + 1;

  sobel_window_gen #(.IMG_W(4), .IMG_H(4)) u_dut_a (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .pi_flag   (pi_flag_s[0]),
    .pi_data   (pi_data_s[0]),
`ifdef SOBEL_WIN_SOF_EN
    .po_sof    (po_sof_s[0]),
`endif
    .po_flag   (po_flag_s[0]),
    .po_win    (po_win_s[0])
  );

  sobel_window_gen #(.IMG_W(5), .IMG_H(3)) u_dut_b (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .pi_flag   (pi_flag_s[1]),
    .pi_data   (pi_data_s[1]),
`ifdef SOBEL_WIN_SOF_EN
    .po_sof    (po_sof_s[1]),
`endif
    .po_flag   (po_flag_s[1]),
    .po_win    (po_win_s[1])
  );

  // Per-cycle scoreboard: a strobe is required exactly on the due cycle of the queue head.
  always @(negedge sys_clk) begin
    for (int s = 0; s < 2; s++) begin
      automatic bit ef = (q[s].size() > 0) && (q[s][0].due == edge_cnt);
      n_assert++;
      assert (po_flag_s[s] === ef) else begin
        n_fail++;
        $error("FAIL flag_%0d edge=%0d observed=%b expected=%b", s, edge_cnt, po_flag_s[s], ef);
      end
      if (ef) begin
        n_assert++;
        assert (po_win_s[s] === q[s][0].win) else begin
          n_fail++;
          $error("FAIL win_%0d edge=%0d observed=%h expected=%h", s, edge_cnt, po_win_s[s], q[s][0].win);
        end
      end
`ifdef SOBEL_WIN_SOF_EN
      n_assert++;
      assert (po_sof_s[s] === (ef && q[s][0].sof)) else begin
        n_fail++;
        $error("FAIL sof_%0d edge=%0d observed=%b expected=%b", s, edge_cnt, po_sof_s[s], ef && q[s][0].sof);
      end
`endif
      if (po_flag_s[s] === 1'b1) begin
        if (pulse_cnt[s] < 16) win_log[s][pulse_cnt[s]] = po_win_s[s];
        pulse_cnt[s]++;
      end
      while (q[s].size() > 0 && q[s][0].due <= edge_cnt) void'(q[s].pop_front());
    end
  end

  task automatic send(input int s, input logic [7:0] d, input int gap);
    exp_t e;
    int r, c;
    r = row_m[s];
    c = col_m[s];
    img[s][r][c] = d;
    if (r >= 2 && c >= 2) begin
      e.win = {img[s][r-2][c-2], img[s][r-2][c-1], img[s][r-2][c],
               img[s][r-1][c-2], img[s][r-1][c-1], img[s][r-1][c],
               img[s][r][c-2],   img[s][r][c-1],   img[s][r][c]};
      e.due = edge_cnt + 2;
      e.sof = (r == 2 && c == 2);
      q[s].push_back(e);
    end
    col_m[s] = (c + 1) % w_s[s];
    if (c + 1 == w_s[s]) row_m[s] = (r + 1) % h_s[s];
    pi_flag_s[s] = 1'b1;
    pi_data_s[s] = d;
    @(posedge sys_clk); #1;
    pi_flag_s[s] = 1'b0;
    repeat (gap) begin @(posedge sys_clk); #1; end
  endtask

  task automatic do_reset(input int cycles);
    sys_rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      q[s].delete();
      row_m[s] = 0;
      col_m[s] = 0;
    end
    repeat (cycles) begin @(posedge sys_clk); #1; end
    for (int s = 0; s < 2; s++) begin
      n_assert++;
      assert (po_flag_s[s] === 1'b0 && po_win_s[s] === 72'h0) else begin
        n_fail++;
        $error("FAIL reset_%0d observed=%b/%h expected=0/0", s, po_flag_s[s], po_win_s[s]);
      end
    end
    sys_rst_n = 1'b1;
  endtask

  task automatic check_int(input string tag, input int observed, input int expected);
    n_assert++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic check_win(input string tag, input logic [71:0] observed, input logic [71:0] expected);
    n_assert++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic drain();
    repeat (4) begin @(posedge sys_clk); #1; end
  endtask

  initial begin
    pi_data_s[0] = '0;
    pi_data_s[1] = '0;
    pulse_cnt[0] = 0;
    pulse_cnt[1] = 0;
    #2;
    do_reset(3);

    // Spaced pixels 1..16
    for (int i = 1; i <= 16; i++) send(0, 8'(i), 4);
    drain();
    check_int("s1_count", pulse_cnt[0], 4);
    check_win("s1_first", win_log[0][0], 72'h01_02_03_05_06_07_09_0A_0B);
    check_win("s1_last",  win_log[0][3], 72'h06_07_08_0A_0B_0C_0E_0F_10);

    // Back-to-back single frame
    pulse_cnt[0] = 0;
    for (int i = 1; i <= 16; i++) send(0, 8'(i), 0);
    drain();
    check_int("s2_count", pulse_cnt[0], 4);
    check_win("s2_first", win_log[0][0], 72'h01_02_03_05_06_07_09_0A_0B);

    // Two frames back-to-back
    pulse_cnt[0] = 0;
    for (int i = 1; i <= 32; i++) send(0, 8'(i), 0);
    drain();
    check_int("s3_count", pulse_cnt[0], 8);
    check_win("s3_fifth", win_log[0][4], 72'h11_12_13_15_16_17_19_1A_1B);

    // Reset after pixel 10, then a full frame
    pulse_cnt[0] = 0;
    for (int i = 1; i <= 10; i++) send(0, 8'(i), 4);
    do_reset(3);
    check_int("s4_pre_reset", pulse_cnt[0], 0);
    for (int i = 1; i <= 16; i++) send(0, 8'(i), 4);
    drain();
    check_int("s4_count", pulse_cnt[0], 4);
    check_win("s4_first", win_log[0][0], 72'h01_02_03_05_06_07_09_0A_0B);

    // 5x3 image with random gaps
    pulse_cnt[1] = 0;
    for (int i = 1; i <= 15; i++) send(1, 8'(i), int'($urandom_range(0, 20)));
    drain();
    check_int("s6_count", pulse_cnt[1], 3);
    check_win("s6_second", win_log[1][1], 72'h02_03_04_07_08_09_0C_0D_0E);

    // Random pixel values and gaps over three frames
    pulse_cnt[0] = 0;
    for (int i = 0; i < 48; i++) send(0, 8'($urandom), int'($urandom_range(0, 3)));
    drain();
    check_int("rnd_count", pulse_cnt[0], 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
